// File: rtl/pc_gen_ras.sv
// ============================================================================
// Module   : pc_gen_ras
// Purpose  : Next-PC generator for the fetch stage with a circular
//            return-address stack (RAS) for call/return prediction.
//            Next fetch address is chosen by priority:
//              debug reset > redirect > hold > RAS pop > branch predict
//              > sequential.
//            The PC advances only when fetch accepts the current PC.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   1       clock
//   rst               in   1       asynchronous reset, active-low
//   jtag_reset_flag_i in   1       synchronous reset request from debug
//   jump_flag_i       in   1       redirect (resolved branch/jump/trap)
//   jump_addr_i       in   ADDR_W  redirect target
//   hold_flag_i       in   HOLD_W  pipeline hold level
//   stall_flag_i      in   1       stall request
//   fetch_ready_i     in   1       fetch accepts pc_o this cycle
//   prdt_taken_i      in   1       branch predicted taken
//   prdt_addr_i       in   ADDR_W  predicted branch target
//   ras_push_i        in   1       call predicted: push return address
//   ras_push_addr_i   in   ADDR_W  return address to push
//   ras_pop_i         in   1       return predicted: target from RAS top
//   pc_o              out  ADDR_W  current fetch PC
//   pc_valid_o        out  1       pc_o is a valid fetch request
//   ras_empty_o       out  1       RAS holds no entries
//   ras_count_o       out  CNT_W   live RAS entries
// ============================================================================
`default_nettype none

module pc_gen_ras #(
  parameter int                  ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]   RESET_ADDR  = '0,
  parameter int                  INST_STEP   = 4,
  parameter int                  HOLD_W      = 3,
  parameter logic [HOLD_W-1:0]   HOLD_PC_LVL = 3'b001,
  parameter int                  RAS_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           jtag_reset_flag_i,
  input  logic                           jump_flag_i,
  input  logic [ADDR_W-1:0]              jump_addr_i,
  input  logic [HOLD_W-1:0]              hold_flag_i,
  input  logic                           stall_flag_i,
  input  logic                           fetch_ready_i,
  input  logic                           prdt_taken_i,
  input  logic [ADDR_W-1:0]              prdt_addr_i,
  input  logic                           ras_push_i,
  input  logic [ADDR_W-1:0]              ras_push_addr_i,
  input  logic                           ras_pop_i,
  output logic [ADDR_W-1:0]              pc_o,
  output logic                           pc_valid_o,
  output logic                           ras_empty_o,
  output logic [$clog2(RAS_DEPTH):0]     ras_count_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] STEP_VAL  = ADDR_W'(INST_STEP);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // ras_ptr is the next free slot; the top of stack sits at ras_ptr-1.
  // Because the depth is a power of two the pointer wraps naturally, so a
  // push onto a full stack lands on the oldest entry.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [CNT_W-1:0]  ras_cnt;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              adv;
  logic              ras_empty;
  logic              ras_full;
  logic              pop_hit;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ras_top;

  logic [ADDR_W-1:0] pc_next;
  logic              valid_next;
  logic [PTR_W-1:0]  ptr_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_idx;

  assign adv = !jump_flag_i && !stall_flag_i &&
               (hold_flag_i < HOLD_PC_LVL) && fetch_ready_i;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_FULL);
  assign top_idx   = ras_ptr - PTR_ONE;
  assign ras_top   = ras_mem[top_idx];

  // A pop only counts when there is something to pop; a pop on an empty
  // stack falls through to the branch-predict / sequential choice.
  assign pop_hit = ras_pop_i && !ras_empty;

  always_comb begin
    pc_next    = pc_o;
    valid_next = 1'b1;
    ptr_next   = ras_ptr;
    cnt_next   = ras_cnt;
    mem_we     = 1'b0;
    mem_idx    = ras_ptr;

    if (jtag_reset_flag_i) begin
      pc_next    = RESET_ADDR;
      valid_next = 1'b0;
      ptr_next   = '0;
      cnt_next   = '0;
    end else if (jump_flag_i) begin
      pc_next = jump_addr_i;
    end else if (adv) begin
      // PC selection
      if (pop_hit) begin
        pc_next = ras_top;
      end else if (prdt_taken_i) begin
        pc_next = prdt_addr_i;
      end else begin
        pc_next = pc_o + STEP_VAL;
      end

      // RAS update
      if (ras_push_i && pop_hit) begin
        // Return then call in one cycle: the consumed top is replaced in
        // place by the new return address, depth unchanged.
        mem_we  = 1'b1;
        mem_idx = top_idx;
      end else if (ras_push_i) begin
        mem_we   = 1'b1;
        mem_idx  = ras_ptr;
        ptr_next = ras_ptr + PTR_ONE;
        if (!ras_full) begin
          cnt_next = ras_cnt + CNT_ONE;
        end
      end else if (pop_hit) begin
        ptr_next = top_idx;
        cnt_next = ras_cnt - CNT_ONE;
      end
    end
    // !adv without redirect: everything holds (defaults above).
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o       <= RESET_ADDR;
      pc_valid_o <= 1'b0;
      ras_ptr    <= '0;
      ras_cnt    <= '0;
    end else begin
      pc_o       <= pc_next;
      pc_valid_o <= valid_next;
      ras_ptr    <= ptr_next;
      ras_cnt    <= cnt_next;
    end
  end

  // Stack storage carries no reset; validity is tracked by ras_cnt alone.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ras_mem[mem_idx] <= ras_push_addr_i;
    end
  end

  assign ras_empty_o = ras_empty;
  assign ras_count_o = ras_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
// ============================================================================
// Module   : tb_pc_gen_ras
// Purpose  : Directed self-checking bench for pc_gen_ras (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen_ras;

  logic        clk;
  logic        rst;
  logic        jtag_reset_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        stall_flag_i;
  logic        fetch_ready_i;
  logic        prdt_taken_i;
  logic [31:0] prdt_addr_i;
  logic        ras_push_i;
  logic [31:0] ras_push_addr_i;
  logic        ras_pop_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        ras_empty_o;
  logic [2:0]  ras_count_o;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen_ras dut (
    .clk               (clk),
    .rst               (rst),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .stall_flag_i      (stall_flag_i),
    .fetch_ready_i     (fetch_ready_i),
    .prdt_taken_i      (prdt_taken_i),
    .prdt_addr_i       (prdt_addr_i),
    .ras_push_i        (ras_push_i),
    .ras_push_addr_i   (ras_push_addr_i),
    .ras_pop_i         (ras_pop_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .ras_empty_o       (ras_empty_o),
    .ras_count_o       (ras_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a);
    ras_push_i      = 1'b1;
    ras_push_addr_i = a;
    step();
    ras_push_i      = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_pc);
    ras_pop_i = 1'b1;
    step();
    ras_pop_i = 1'b0;
    check(tag, pc_o, exp_pc);
  endtask

  initial begin
    rst               = 1'b0;
    jtag_reset_flag_i = 1'b0;
    jump_flag_i       = 1'b0;
    jump_addr_i       = '0;
    hold_flag_i       = '0;
    stall_flag_i      = 1'b0;
    fetch_ready_i     = 1'b1;
    prdt_taken_i      = 1'b0;
    prdt_addr_i       = '0;
    ras_push_i        = 1'b0;
    ras_push_addr_i   = '0;
    ras_pop_i         = 1'b0;

    // ---- 1: reset and sequential fetch ----
    step();
    step();
    check("rst_pc",    pc_o, 32'h0);
    check("rst_valid", {31'b0, pc_valid_o}, 32'd0);
    check("rst_empty", {31'b0, ras_empty_o}, 32'd1);
    check("rst_count", {29'b0, ras_count_o}, 32'd0);
    rst = 1'b1;
    step();
    check("seq_pc1",   pc_o, 32'h4);
    check("seq_valid", {31'b0, pc_valid_o}, 32'd1);
    step();
    check("seq_pc2",   pc_o, 32'h8);
    step();
    check("seq_pc3",   pc_o, 32'hC);

    // ---- 2: redirect beats stall; stall/hold/not-ready freeze ----
    stall_flag_i = 1'b1;
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h100;
    step();
    check("jump_over_stall", pc_o, 32'h100);
    jump_flag_i = 1'b0;
    step();
    check("stall_hold", pc_o, 32'h100);
    // a push during a stall must not reach the RAS
    push(32'hDEAD);
    check("stall_no_push", {29'b0, ras_count_o}, 32'd0);
    stall_flag_i = 1'b0;
    hold_flag_i  = 3'b001;
    step();
    check("hold_lvl", pc_o, 32'h100);
    hold_flag_i   = 3'b000;
    fetch_ready_i = 1'b0;
    step();
    check("not_ready", pc_o, 32'h100);
    fetch_ready_i = 1'b1;
    step();
    check("resume", pc_o, 32'h104);

    // ---- 3: fill past depth, then drain ----
    push(32'h10);
    push(32'h20);
    push(32'h30);
    push(32'h40);
    push(32'h50);
    check("full_count", {29'b0, ras_count_o}, 32'd4);
    check("full_empty", {31'b0, ras_empty_o}, 32'd0);
    pop_check("pop_50", 32'h50);
    pop_check("pop_40", 32'h40);
    pop_check("pop_30", 32'h30);
    pop_check("pop_20", 32'h20);
    check("drained_empty", {31'b0, ras_empty_o}, 32'd1);
    check("drained_count", {29'b0, ras_count_o}, 32'd0);

    // ---- 4: pop on empty falls back to prediction / sequential ----
    prdt_taken_i = 1'b1;
    prdt_addr_i  = 32'h200;
    pop_check("pop_empty_prdt", 32'h200);
    check("pop_empty_count", {29'b0, ras_count_o}, 32'd0);
    prdt_taken_i = 1'b0;
    pop_check("pop_empty_seq", 32'h204);

    // ---- 5: simultaneous push + pop ----
    push(32'h80);
    check("one_entry", {29'b0, ras_count_o}, 32'd1);
    ras_push_i      = 1'b1;
    ras_push_addr_i = 32'h90;
    pop_check("pushpop_pc", 32'h80);
    ras_push_i = 1'b0;
    check("pushpop_count", {29'b0, ras_count_o}, 32'd1);
    pop_check("pop_90", 32'h90);
    check("pushpop_drained", {29'b0, ras_count_o}, 32'd0);

    // ---- 6: debug reset mid-run, then address wrap ----
    push(32'h1000);
    push(32'h2000);
    push(32'h3000);
    check("pre_jtag_count", {29'b0, ras_count_o}, 32'd3);
    jtag_reset_flag_i = 1'b1;
    step();
    jtag_reset_flag_i = 1'b0;
    check("jtag_pc",    pc_o, 32'h0);
    check("jtag_valid", {31'b0, pc_valid_o}, 32'd0);
    check("jtag_count", {29'b0, ras_count_o}, 32'd0);
    check("jtag_empty", {31'b0, ras_empty_o}, 32'd1);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_flag_i = 1'b0;
    check("wrap_jump",  pc_o, 32'hFFFF_FFFC);
    check("post_jtag_valid", {31'b0, pc_valid_o}, 32'd1);
    step();
    check("wrap_pc",    pc_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
